// File: rtl/dmem_arb_pkg.sv
// -----------------------------------------------------------------------------
// dmem_arb_pkg
// Shared types and constants for the data-memory arbiter.
//   arb_state_e : arbiter FSM states (idle, CPU transfer, host transfer)
//   owner_e     : requester identity used for grant and round-robin history
//   ERR_DATA    : read data returned when a transfer times out
//   Def*        : default widths / timeout for the arbiter parameters
// -----------------------------------------------------------------------------
package dmem_arb_pkg;

   localparam int unsigned DefAddrW         = 32;
   localparam int unsigned DefDataW         = 32;
   localparam int unsigned DefTimeoutCycles = 15;

   localparam logic [31:0] ERR_DATA = 32'hDEADBEEF;

   typedef enum logic [1:0] {
      StIdle     = 2'd0,
      StCpuXfer  = 2'd1,
      StHostXfer = 2'd2
   } arb_state_e;

   typedef enum logic {
      OwnCpu  = 1'b0,
      OwnHost = 1'b1
   } owner_e;

   // The requester that did not own the bus last time.
   function automatic owner_e other_owner(owner_e o);
      return (o == OwnCpu) ? OwnHost : OwnCpu;
   endfunction

endpackage

// File: rtl/dmem_arb_pick.sv
// -----------------------------------------------------------------------------
// dmem_arb_pick
// Combinational two-way round-robin pick between the CPU and the host.
// A lone requester always wins; on a tie the requester that was not served
// last wins.
//   cpu_req_i    in  CPU request
//   host_req_i   in  host request
//   last_owner_i in  owner of the most recently completed transfer
//   grant_o      out some requester is active
//   owner_o      out chosen requester (meaningful only with grant_o)
// -----------------------------------------------------------------------------
module dmem_arb_pick
   import dmem_arb_pkg::*;
(
   input  logic   cpu_req_i,
   input  logic   host_req_i,
   input  owner_e last_owner_i,
   output logic   grant_o,
   output owner_e owner_o
);

   always_comb begin
      grant_o = cpu_req_i | host_req_i;
      owner_o = OwnCpu;
      unique case ({cpu_req_i, host_req_i})
         2'b10:   owner_o = OwnCpu;
         2'b01:   owner_o = OwnHost;
         2'b11:   owner_o = other_owner(last_owner_i);
         default: owner_o = OwnCpu;
      endcase
   end

endmodule

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
// Arbitrates a single shared data memory between the CPU data port and a
// UART-host debug port. One transfer is in flight at a time; the winning
// request is latched at grant and presented on mem_* until mem_ready.
//
// Optional feature macro: DMEM_ARB_TIMEOUT_EN
//   When defined, a transfer that sees no mem_ready for TIMEOUT_CYCLES cycles
//   completes with rdata = ERR_DATA and sets the sticky arb_err flag.
//   When undefined, transfers wait forever and arb_err is tied low.
//
// Ports
//   clk, rst_n                         clock, synchronous active-low reset
//   cpu_req/we/addr/wdata      in      CPU request
//   cpu_stall                  out     cpu_req & ~cpu_valid
//   cpu_valid, cpu_rdata       out     CPU completion pulse and read data
//   host_req/we/addr/wdata     in      host request
//   host_valid, host_rdata     out     host completion pulse and read data
//   mem_memread/memwrite/addr/wdata out memory command (0 when idle)
//   mem_rdata, mem_ready       in      memory response
//   arb_err                    out     sticky timeout flag
// -----------------------------------------------------------------------------
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int unsigned ADDR_W         = DefAddrW,
   parameter int unsigned DATA_W         = DefDataW,
   parameter int unsigned TIMEOUT_CYCLES = DefTimeoutCycles
) (
   input  logic              clk,
   input  logic              rst_n,
   // CPU data port
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_stall,
   output logic              cpu_valid,
   output logic [DATA_W-1:0] cpu_rdata,
   // Host debug port
   input  logic              host_req,
   input  logic              host_we,
   input  logic [ADDR_W-1:0] host_addr,
   input  logic [DATA_W-1:0] host_wdata,
   output logic              host_valid,
   output logic [DATA_W-1:0] host_rdata,
   // Shared memory
   output logic              mem_memread,
   output logic              mem_memwrite,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ready,
   // Status
   output logic              arb_err
);

   arb_state_e        state_q;
   owner_e            last_owner_q;
   logic              we_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;

   logic              grant;
   owner_e            grant_owner;
   logic              in_xfer;
   logic              done_ok;
   logic              timeout_hit;
   logic              done;
   logic [DATA_W-1:0] xfer_rdata;

   dmem_arb_pick u_pick (
      .cpu_req_i    (cpu_req),
      .host_req_i   (host_req),
      .last_owner_i (last_owner_q),
      .grant_o      (grant),
      .owner_o      (grant_owner)
   );

   assign in_xfer = (state_q == StCpuXfer) || (state_q == StHostXfer);

   // Gated by rst_n so a reset landing on the completing cycle aborts the
   // transfer without a valid pulse.
   assign done_ok = in_xfer & mem_ready & rst_n;

`ifdef DMEM_ARB_TIMEOUT_EN
   localparam logic [7:0]        ToLast  = 8'(TIMEOUT_CYCLES - 1);
   localparam logic [DATA_W-1:0] ErrData = DATA_W'(ERR_DATA);

   logic [7:0] cnt_q;
   logic       arb_err_q;

   // cnt_q is the number of XFER cycles already spent, so the hit fires on
   // the TIMEOUT_CYCLES-th cycle of the transfer. A real mem_ready wins.
   assign timeout_hit = in_xfer & ~mem_ready & rst_n & (cnt_q == ToLast);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q     <= '0;
         arb_err_q <= 1'b0;
      end else begin
         if (in_xfer && !done) begin
            cnt_q <= cnt_q + 8'd1;
         end else begin
            cnt_q <= '0;
         end
         if (timeout_hit) begin
            arb_err_q <= 1'b1;
         end
      end
   end

   assign arb_err = arb_err_q;

   always_comb begin
      if (timeout_hit) begin
         xfer_rdata = ErrData;
      end else if (we_q) begin
         xfer_rdata = '0;
      end else begin
         xfer_rdata = mem_rdata;
      end
   end
`else
   logic [7:0] unused_timeout;
   assign unused_timeout = 8'(TIMEOUT_CYCLES);
   assign timeout_hit    = 1'b0;
   assign arb_err        = 1'b0;
   assign xfer_rdata     = we_q ? '0 : mem_rdata;
`endif

   assign done = done_ok | timeout_hit;

   // Arbiter FSM: grant from IDLE, hold the latched request until done.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= StIdle;
         last_owner_q <= OwnHost;
         we_q         <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (grant) begin
                  if (grant_owner == OwnCpu) begin
                     we_q    <= cpu_we;
                     addr_q  <= cpu_addr;
                     wdata_q <= cpu_wdata;
                     state_q <= StCpuXfer;
                  end else begin
                     we_q    <= host_we;
                     addr_q  <= host_addr;
                     wdata_q <= host_wdata;
                     state_q <= StHostXfer;
                  end
               end
            end
            StCpuXfer: begin
               if (done) begin
                  last_owner_q <= OwnCpu;
                  state_q      <= StIdle;
               end
            end
            StHostXfer: begin
               if (done) begin
                  last_owner_q <= OwnHost;
                  state_q      <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign cpu_valid  = done & (state_q == StCpuXfer);
   assign host_valid = done & (state_q == StHostXfer);
   assign cpu_rdata  = cpu_valid ? xfer_rdata : '0;
   assign host_rdata = host_valid ? xfer_rdata : '0;
   assign cpu_stall  = cpu_req & ~cpu_valid;

   assign mem_memread  = in_xfer & ~we_q;
   assign mem_memwrite = in_xfer & we_q;
   assign mem_addr     = in_xfer ? addr_q : '0;
   assign mem_wdata    = in_xfer ? wdata_q : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
// Cycle-by-cycle vector table for the arbiter plus hand-written sequences for
// reset during a transfer and the timeout / wait-forever behaviour.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cpu_req, cpu_we, host_req, host_we, mem_ready;
   logic [31:0] cpu_addr, cpu_wdata, host_addr, host_wdata, mem_rdata;
   logic        cpu_stall, cpu_valid, host_valid;
   logic        mem_memread, mem_memwrite, arb_err;
   logic [31:0] cpu_rdata, host_rdata, mem_addr, mem_wdata;

   always #5 clk = ~clk;

   dmem_arbiter dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .cpu_req      (cpu_req),
      .cpu_we       (cpu_we),
      .cpu_addr     (cpu_addr),
      .cpu_wdata    (cpu_wdata),
      .cpu_stall    (cpu_stall),
      .cpu_valid    (cpu_valid),
      .cpu_rdata    (cpu_rdata),
      .host_req     (host_req),
      .host_we      (host_we),
      .host_addr    (host_addr),
      .host_wdata   (host_wdata),
      .host_valid   (host_valid),
      .host_rdata   (host_rdata),
      .mem_memread  (mem_memread),
      .mem_memwrite (mem_memwrite),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .mem_rdata    (mem_rdata),
      .mem_ready    (mem_ready),
      .arb_err      (arb_err)
   );

   typedef struct {
      logic [31:0] rst, creq, cwe, caddr, cwd;
      logic [31:0] hreq, hwe, haddr, hwd;
      logic [31:0] mrdy, mrd;
      logic [31:0] stall, cv, crd, hv, hrd, rd, wr, maddr, mwd;
   } vec_t;

   vec_t tbl[$];
   int   n_pass  = 0;
   int   n_total = 0;

   function automatic vec_t mk(
      logic [31:0] rst, logic [31:0] creq, logic [31:0] cwe, logic [31:0] caddr,
      logic [31:0] cwd, logic [31:0] hreq, logic [31:0] hwe, logic [31:0] haddr,
      logic [31:0] hwd, logic [31:0] mrdy, logic [31:0] mrd, logic [31:0] stall,
      logic [31:0] cv, logic [31:0] crd, logic [31:0] hv, logic [31:0] hrd,
      logic [31:0] rd, logic [31:0] wr, logic [31:0] maddr, logic [31:0] mwd);
      vec_t v;
      v.rst = rst;   v.creq = creq; v.cwe = cwe;   v.caddr = caddr; v.cwd = cwd;
      v.hreq = hreq; v.hwe = hwe;   v.haddr = haddr; v.hwd = hwd;
      v.mrdy = mrdy; v.mrd = mrd;
      v.stall = stall; v.cv = cv; v.crd = crd; v.hv = hv; v.hrd = hrd;
      v.rd = rd; v.wr = wr; v.maddr = maddr; v.mwd = mwd;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic drive(input vec_t v);
      rst_n      = v.rst[0];
      cpu_req    = v.creq[0];
      cpu_we     = v.cwe[0];
      cpu_addr   = v.caddr;
      cpu_wdata  = v.cwd;
      host_req   = v.hreq[0];
      host_we    = v.hwe[0];
      host_addr  = v.haddr;
      host_wdata = v.hwd;
      mem_ready  = v.mrdy[0];
      mem_rdata  = v.mrd;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int          n;
      logic        got;
      logic [31:0] rdv;

      //                rst creq we caddr  cwd hreq we haddr hwd rdy mrd
      //                  stall cv crd hv hrd rd wr maddr mwd
      // Reset state, lone CPU read with data on the second cycle, ready in IDLE.
      tbl.push_back(mk(0, 0,0,0,0,      0,0,0,0,      0,0,
                       0,0,0,0,0, 0,0,0,0));
      tbl.push_back(mk(1, 1,0,'h100,0,  0,0,0,0,      0,0,
                       1,0,0,0,0, 0,0,0,0));
      tbl.push_back(mk(1, 1,0,'h100,0,  0,0,0,0,      0,0,
                       1,0,0,0,0, 1,0,'h100,0));
      tbl.push_back(mk(1, 1,0,'h100,0,  0,0,0,0,      1,'h12345678,
                       0,1,'h12345678,0,0, 1,0,'h100,0));
      tbl.push_back(mk(1, 0,0,0,0,      0,0,0,0,      0,0,
                       0,0,0,0,0, 0,0,0,0));
      tbl.push_back(mk(1, 0,0,0,0,      0,0,0,0,      1,'hFFFF,
                       0,0,0,0,0, 0,0,0,0));
      // Tie after a CPU transfer: host wins, then CPU.
      tbl.push_back(mk(1, 1,0,'h600,0,  1,0,'h700,0,  0,0,
                       1,0,0,0,0, 0,0,0,0));
      tbl.push_back(mk(1, 1,0,'h600,0,  1,0,'h700,0,  0,0,
                       1,0,0,0,0, 1,0,'h700,0));
      tbl.push_back(mk(1, 1,0,'h600,0,  1,0,'h700,0,  1,1,
                       1,0,0,1,1, 1,0,'h700,0));
      tbl.push_back(mk(1, 1,0,'h600,0,  0,0,0,0,      0,0,
                       1,0,0,0,0, 0,0,0,0));
      tbl.push_back(mk(1, 1,0,'h600,0,  0,0,0,0,      0,0,
                       1,0,0,0,0, 1,0,'h600,0));
      tbl.push_back(mk(1, 1,0,'h600,0,  0,0,0,0,      1,2,
                       0,1,2,0,0, 1,0,'h600,0));
      tbl.push_back(mk(1, 0,0,0,0,      0,0,0,0,      0,0,
                       0,0,0,0,0, 0,0,0,0));
      // Reset, then tie: CPU first, one IDLE cycle, host once.
      tbl.push_back(mk(0, 0,0,0,0,      0,0,0,0,      0,0,
                       0,0,0,0,0, 0,0,0,0));
      tbl.push_back(mk(1, 1,0,'h200,0,  1,0,'h300,0,  0,0,
                       1,0,0,0,0, 0,0,0,0));
      tbl.push_back(mk(1, 1,0,'h200,0,  1,0,'h300,0,  0,0,
                       1,0,0,0,0, 1,0,'h200,0));
      tbl.push_back(mk(1, 1,0,'h200,0,  1,0,'h300,0,  1,'hAAAA0001,
                       0,1,'hAAAA0001,0,0, 1,0,'h200,0));
      tbl.push_back(mk(1, 0,0,0,0,      1,0,'h300,0,  0,0,
                       0,0,0,0,0, 0,0,0,0));
      tbl.push_back(mk(1, 0,0,0,0,      1,0,'h300,0,  0,0,
                       0,0,0,0,0, 1,0,'h300,0));
      tbl.push_back(mk(1, 0,0,0,0,      1,0,'h300,0,  1,'hBBBB0002,
                       0,0,0,1,'hBBBB0002, 1,0,'h300,0));
      tbl.push_back(mk(1, 0,0,0,0,      0,0,0,0,      0,0,
                       0,0,0,0,0, 0,0,0,0));
      // Host write arrives during a CPU read; CPU changes fields after grant.
      tbl.push_back(mk(1, 1,0,'h104,0,  0,0,0,0,      0,0,
                       1,0,0,0,0, 0,0,0,0));
      tbl.push_back(mk(1, 1,0,'h104,0,  1,1,'h40,'hA5, 0,0,
                       1,0,0,0,0, 1,0,'h104,0));
      tbl.push_back(mk(1, 1,1,'h999,'h33, 1,1,'h40,'hA5, 0,0,
                       1,0,0,0,0, 1,0,'h104,0));
      tbl.push_back(mk(1, 1,1,'h999,'h33, 1,1,'h40,'hA5, 1,'h5555,
                       0,1,'h5555,0,0, 1,0,'h104,0));
      tbl.push_back(mk(1, 0,0,0,0,      1,1,'h40,'hA5, 0,0,
                       0,0,0,0,0, 0,0,0,0));
      tbl.push_back(mk(1, 0,0,0,0,      1,1,'h40,'hA5, 0,0,
                       0,0,0,0,0, 0,1,'h40,'hA5));
      tbl.push_back(mk(1, 0,0,0,0,      1,1,'h40,'hA5, 1,'h77,
                       0,0,0,1,0, 0,1,'h40,'hA5));
      tbl.push_back(mk(1, 0,0,0,0,      0,0,0,0,      0,0,
                       0,0,0,0,0, 0,0,0,0));

      drive(mk(0, 0,0,0,0, 0,0,0,0, 0,0, 0,0,0,0,0, 0,0,0,0));
      repeat (2) @(posedge clk);
      #1;

      for (int i = 0; i < tbl.size(); i++) begin
         drive(tbl[i]);
         @(negedge clk);
         check($sformatf("v%0d cpu_stall", i),  32'(cpu_stall),    tbl[i].stall);
         check($sformatf("v%0d cpu_valid", i),  32'(cpu_valid),    tbl[i].cv);
         check($sformatf("v%0d cpu_rdata", i),  cpu_rdata,         tbl[i].crd);
         check($sformatf("v%0d host_valid", i), 32'(host_valid),   tbl[i].hv);
         check($sformatf("v%0d host_rdata", i), host_rdata,        tbl[i].hrd);
         check($sformatf("v%0d mem_memread", i), 32'(mem_memread), tbl[i].rd);
         check($sformatf("v%0d mem_memwrite", i), 32'(mem_memwrite), tbl[i].wr);
         check($sformatf("v%0d mem_addr", i),   mem_addr,          tbl[i].maddr);
         check($sformatf("v%0d mem_wdata", i),  mem_wdata,         tbl[i].mwd);
         check($sformatf("v%0d arb_err", i),    32'(arb_err),      32'd0);
         next_cycle();
      end

      // Reset during a host transfer, after a CPU transfer made the CPU last owner.
      drive(mk(1, 1,0,'h900,0, 0,0,0,0, 0,0, 0,0,0,0,0, 0,0,0,0));
      next_cycle();
      mem_ready = 1'b1;
      @(negedge clk);
      check("r cpu_valid", 32'(cpu_valid), 32'd1);
      next_cycle();
      drive(mk(1, 0,0,0,0, 1,0,'h80,0, 0,0, 0,0,0,0,0, 0,0,0,0));
      next_cycle();
      @(negedge clk);
      check("r host_xfer read", 32'(mem_memread), 32'd1);
      check("r host_xfer addr", mem_addr, 32'h80);
      next_cycle();
      rst_n     = 1'b0;
      mem_ready = 1'b1;
      mem_rdata = 32'hCAFE;
      @(negedge clk);
      check("r no host_valid in reset", 32'(host_valid), 32'd0);
      check("r no host_rdata in reset", host_rdata, 32'd0);
      next_cycle();
      drive(mk(1, 1,0,'h910,0, 1,0,'h84,0, 0,0, 0,0,0,0,0, 0,0,0,0));
      @(negedge clk);
      check("r mem_memread after reset", 32'(mem_memread), 32'd0);
      check("r mem_memwrite after reset", 32'(mem_memwrite), 32'd0);
      check("r mem_addr after reset", mem_addr, 32'd0);
      check("r host_valid after reset", 32'(host_valid), 32'd0);
      next_cycle();
      @(negedge clk);
      check("r tie grants cpu read", 32'(mem_memread), 32'd1);
      check("r tie grants cpu addr", mem_addr, 32'h910);
      next_cycle();
      mem_ready = 1'b1;
      mem_rdata = 32'h4242;
      @(negedge clk);
      check("r cpu_valid after tie", 32'(cpu_valid), 32'd1);
      check("r cpu_rdata after tie", cpu_rdata, 32'h4242);
      next_cycle();
      drive(mk(1, 0,0,0,0, 1,0,'h84,0, 0,0, 0,0,0,0,0, 0,0,0,0));
      next_cycle();
      mem_ready = 1'b1;
      next_cycle();
      drive(mk(1, 0,0,0,0, 0,0,0,0, 0,0, 0,0,0,0,0, 0,0,0,0));
      next_cycle();

      // Transfer with mem_ready held low.
      drive(mk(1, 1,0,'h10,0, 0,0,0,0, 0,0, 0,0,0,0,0, 0,0,0,0));
      n   = 0;
      got = 1'b0;
      rdv = '0;
      for (int k = 0; k < 40 && !got; k++) begin
         @(negedge clk);
         if (mem_memread) n++;
         if (cpu_valid) begin
            got = 1'b1;
            rdv = cpu_rdata;
         end
         next_cycle();
      end
`ifdef DMEM_ARB_TIMEOUT_EN
      check("to valid seen", 32'(got), 32'd1);
      check("to xfer cycles", 32'(n), 32'd15);
      check("to rdata", rdv, 32'hDEADBEEF);
      cpu_req = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check($sformatf("to arb_err sticky %0d", k), 32'(arb_err), 32'd1);
         check($sformatf("to idle after %0d", k), 32'(mem_memread), 32'd0);
         next_cycle();
      end
      rst_n = 1'b0;
      next_cycle();
      rst_n = 1'b1;
      @(negedge clk);
      check("to arb_err cleared", 32'(arb_err), 32'd0);
      next_cycle();
`else
      check("wait no valid", 32'(got), 32'd0);
      check("wait xfer cycles", 32'(n), 32'd39);
      check("wait arb_err", 32'(arb_err), 32'd0);
      mem_ready = 1'b1;
      mem_rdata = 32'h0BAD_F00D;
      @(negedge clk);
      check("wait late valid", 32'(cpu_valid), 32'd1);
      check("wait late rdata", cpu_rdata, 32'h0BAD_F00D);
      next_cycle();
      cpu_req   = 1'b0;
      mem_ready = 1'b0;
      next_cycle();
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
